// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with runtime frame format, error flags and receive FIFO
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : each bit is the 2-of-3 vote of rx_s around the sample point and
//               the decision is taken one cycle after the sample point.
//               A divider below 4 keeps the receiver in IDLE.
//   undefined : each bit is a single sample at the sample point.
//               A divider below 2 keeps the receiver in IDLE.
//
// Ports:
//   clock_i          clock, all logic on posedge
//   reset_ni         asynchronous active-low reset
//   serial_i         asynchronous serial line, idle high
//   clock_divider_i  clock cycles per bit
//   data_bits_i      data bits: 0:5, 1:6, 2:7, 3:8
//   parity_bit_i     1: a parity bit follows the data
//   parity_even_i    1: even parity, 0: odd parity
//   stop_bits_i      0: one stop bit, 1: two stop bits
//   pop_i            consume the head entry while ready_o=1
//   clear_overrun_i  clear overrun_o
//   data_o           head data, zero-extended above the data width
//   ready_o          FIFO non-empty
//   parity_error_o   head entry had a parity mismatch
//   framing_error_o  head entry had a 0 stop bit
//   break_o          head entry is a break
//   overrun_o        sticky: a character was dropped on a full FIFO
//   fifo_count_o     entries held
module uart_rx_fifo #(
    parameter int CLOCK_DIVIDER_WIDTH = 16,
    parameter int FIFO_DEPTH          = 8,
    parameter int FIFO_ADDR_WIDTH     = 3
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic                           serial_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic [1:0]                     data_bits_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    input  logic                           stop_bits_i,
    input  logic                           pop_i,
    input  logic                           clear_overrun_i,
    output logic [7:0]                     data_o,
    output logic                           ready_o,
    output logic                           parity_error_o,
    output logic                           framing_error_o,
    output logic                           break_o,
    output logic                           overrun_o,
    output logic [FIFO_ADDR_WIDTH:0]       fifo_count_o
);

    localparam int CDW = CLOCK_DIVIDER_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CDW-1:0] MIN_DIV = CDW'(4);
`else
    localparam logic [CDW-1:0] MIN_DIV = CDW'(2);
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [1:0]     sync_q;
    logic           rx_s;
    logic [CDW-1:0] div_q, timer_q, half;
    logic           tick, bit_val;
    logic [1:0]     nbits_q;
    logic           par_en_q, par_even_q, stop2_q;
    logic [2:0]     bit_cnt_q;
    logic           stop_cnt_q;
    logic [7:0]     shreg_q;
    logic           par_err_q, frm_err_q, zero_q;
    logic           start_frame, push, last_data, in_frame;
    logic [10:0]    push_word;

    assign rx_s = sync_q[1];
    assign half = {1'b0, div_q[CDW-1:1]};

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) sync_q <= 2'b11;
        else           sync_q <= {sync_q[0], serial_i};
    end

`ifdef UART_RX_MAJORITY_EN
    // hist_q[1] holds rx_s from the cycle before the sample point, hist_q[0]
    // the sample point itself; the vote completes with the current rx_s.
    logic [1:0] hist_q;
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) hist_q <= 2'b11;
        else           hist_q <= {hist_q[0], rx_s};
    end
    assign tick    = (timer_q == half - CDW'(1));
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign tick    = (timer_q == half);
    assign bit_val = rx_s;
`endif

    assign last_data = (bit_cnt_q == ({1'b0, nbits_q} + 3'd4));
    assign in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
    // Break: every bit of the frame including the final stop bit sampled 0.
    assign push_word = {zero_q & ~bit_val, frm_err_q | ~bit_val, par_err_q, shreg_q};

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s && clock_divider_i >= MIN_DIV) begin
                    state_d     = S_START;
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (tick) state_d = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && last_data) state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (tick && (stop_cnt_q == stop2_q)) begin
                    push    = 1'b1;
                    state_d = push_word[10] ? S_BREAK_WAIT : S_IDLE;
                end
            end
            S_BREAK_WAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_q      <= '0;
            timer_q    <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            stop2_q    <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            zero_q     <= 1'b0;
        end else if (start_frame) begin
            div_q      <= clock_divider_i;
            timer_q    <= clock_divider_i - CDW'(1);
            nbits_q    <= data_bits_i;
            par_en_q   <= parity_bit_i;
            par_even_q <= parity_even_i;
            stop2_q    <= stop_bits_i;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            zero_q     <= 1'b1;
        end else if (in_frame) begin
            timer_q <= (timer_q == '0) ? div_q - CDW'(1) : timer_q - CDW'(1);
            if (tick) begin
                if (bit_val) zero_q <= 1'b0;
                case (state_q)
                    S_DATA: begin
                        shreg_q[bit_cnt_q] <= bit_val;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: par_err_q <= bit_val != (par_even_q ? ^shreg_q : ~^shreg_q);
                    S_STOP: begin
                        stop_cnt_q <= 1'b1;
                        if (!bit_val) frm_err_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [10:0]                mem_q [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_WIDTH:0]   count_q;
    logic                       full, pop_en, wr_en;
    logic [10:0]                head;

    assign full   = (count_q == DEPTH);
    assign pop_en = pop_i && (count_q != '0);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign wr_en  = push && (!full || pop_en);

    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop_en)      count_q <= count_q + 1'b1;
            else if (!wr_en && pop_en) count_q <= count_q - 1'b1;
            if (push && full && !pop_en) overrun_o <= 1'b1;
            else if (clear_overrun_i)    overrun_o <= 1'b0;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign ready_o         = (count_q != '0);
    assign fifo_count_o    = count_q;
    assign data_o          = ready_o ? head[7:0] : 8'h00;
    assign parity_error_o  = ready_o & head[8];
    assign framing_error_o = ready_o & head[9];
    assign break_o         = ready_o & head[10];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DIV = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int POP_J = 11;
`else
    localparam int POP_J = 10;
`endif

    logic        clock_i = 1'b0;
    logic        reset_ni, serial_i, pop_i, clear_overrun_i;
    logic [15:0] clock_divider_i;
    logic [1:0]  data_bits_i;
    logic        parity_bit_i, parity_even_i, stop_bits_i;
    logic [7:0]  data_o;
    logic        ready_o, parity_error_o, framing_error_o, break_o, overrun_o;
    logic [3:0]  fifo_count_o;

    uart_rx_fifo dut (
        .clock_i(clock_i), .reset_ni(reset_ni), .serial_i(serial_i),
        .clock_divider_i(clock_divider_i), .data_bits_i(data_bits_i),
        .parity_bit_i(parity_bit_i), .parity_even_i(parity_even_i),
        .stop_bits_i(stop_bits_i), .pop_i(pop_i), .clear_overrun_i(clear_overrun_i),
        .data_o(data_o), .ready_o(ready_o), .parity_error_o(parity_error_o),
        .framing_error_o(framing_error_o), .break_o(break_o),
        .overrun_o(overrun_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [7:0] d;
        logic [1:0] nb;
        logic       pe, pev, pflip, s2, szero;
        logic [7:0] ed;
        logic       ep, ef, eb;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       p, f, b;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [7:0] d, input logic p, input logic f, input logic b);
        exp_t e;
        e.d = d; e.p = p; e.f = f; e.b = b;
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: DUT entry with no expectation queued");
        end else begin
            e = sb.pop_front();
            check("data", int'(data_o), int'(e.d));
            check("parity_error", int'(parity_error_o), int'(e.p));
            check("framing_error", int'(framing_error_o), int'(e.f));
            check("break", int'(break_o), int'(e.b));
        end
    endtask

    task automatic pop_entry();
        check_head();
        pop_i = 1'b1;
        @(negedge clock_i);
        pop_i = 1'b0;
    endtask

    task automatic idle(input int cycles);
        serial_i = 1'b1;
        repeat (cycles) @(negedge clock_i);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 400 && !ready_o; i++) @(negedge clock_i);
        check("ready_timeout", int'(ready_o), 1);
    endtask

    task automatic set_fmt(input logic [1:0] nb, input logic pe, input logic pev, input logic s2);
        data_bits_i = nb; parity_bit_i = pe; parity_even_i = pev; stop_bits_i = s2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] nb, input logic pe,
                              input logic pev, input logic pflip, input logic s2,
                              input logic szero, input bit glitch, input bit pop_at_push,
                              input int reset_at_bit);
        logic [11:0] w;
        logic [7:0]  dm;
        logic        v;
        int          n, nbits;
        nbits = int'(nb) + 5;
        dm = d & 8'((1 << nbits) - 1);
        w = '1;
        n = 0;
        w[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin w[n] = dm[i]; n++; end
        if (pe) begin w[n] = (pev ? ^dm : ~^dm) ^ pflip; n++; end
        w[n] = ~szero; n++;
        if (s2) begin w[n] = ~szero; n++; end
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < DIV; j++) begin
                if (k == reset_at_bit && j == 0) begin
                    reset_ni = 1'b0;
                    serial_i = 1'b1;
                    @(negedge clock_i);
                    reset_ni = 1'b1;
                    return;
                end
                v = w[k];
                if (glitch && k >= 1 && k <= nbits && j == 8) v = ~v;
                if (pop_at_push && k == n - 1 && j == POP_J) begin
                    check_head();
                    pop_i = 1'b1;
                end else begin
                    pop_i = 1'b0;
                end
                serial_i = v;
                @(negedge clock_i);
            end
        end
        serial_i = 1'b1;
        pop_i = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h35, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h35, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h35, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h2A, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1A, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'h81, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0};

        serial_i = 1'b1; reset_ni = 1'b0; pop_i = 1'b0; clear_overrun_i = 1'b0;
        clock_divider_i = 16'(DIV);
        set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock_i);
        check("rst_ready", int'(ready_o), 0);
        check("rst_count", int'(fifo_count_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_flags", int'({parity_error_o, framing_error_o, break_o}), 0);
        check("rst_overrun", int'(overrun_o), 0);
        reset_ni = 1'b1;
        idle(20);

        foreach (vecs[i]) begin
            set_fmt(vecs[i].nb, vecs[i].pe, vecs[i].pev, vecs[i].s2);
            expect_entry(vecs[i].ed, vecs[i].ep, vecs[i].ef, vecs[i].eb);
            send_frame(vecs[i].d, vecs[i].nb, vecs[i].pe, vecs[i].pev, vecs[i].pflip,
                       vecs[i].s2, vecs[i].szero, 1'b0, 1'b0, -1);
            idle(DIV);
            wait_ready();
            check("vec_count", int'(fifo_count_o), 1);
            pop_entry();
            check("vec_empty", int'(ready_o), 0);
        end

        // Break: line low 20 bit times gives one entry, nothing further.
        set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
        expect_entry(8'h00, 1'b0, 1'b1, 1'b1);
        serial_i = 1'b0;
        repeat (20 * DIV) @(negedge clock_i);
        check("break_count_low", int'(fifo_count_o), 1);
        idle(3 * DIV);
        check("break_count_high", int'(fifo_count_o), 1);
        pop_entry();
        check("break_empty", int'(ready_o), 0);

        // Short low glitch that has ended before the start-bit sample point.
        serial_i = 1'b0;
        repeat (DIV / 2 - 1) @(negedge clock_i);
        idle(4 * DIV);
        check("glitch_count", int'(fifo_count_o), 0);

        // Nine frames without pop: ninth dropped, overrun set.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_entry(8'(i * 17 + 1), 1'b0, 1'b0, 1'b0);
            send_frame(8'(i * 17 + 1), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            idle(DIV);
        end
        check("ovr_count", int'(fifo_count_o), 8);
        check("ovr_set", int'(overrun_o), 1);
        for (int i = 0; i < 8; i++) pop_entry();
        check("ovr_drained", int'(fifo_count_o), 0);
        check("ovr_sticky", int'(overrun_o), 1);
        clear_overrun_i = 1'b1;
        @(negedge clock_i);
        clear_overrun_i = 1'b0;
        check("ovr_cleared", int'(overrun_o), 0);

        // Nine frames, pop coinciding with the ninth push: nothing lost.
        for (int i = 0; i < 9; i++) begin
            expect_entry(8'(8'hF0 - i), 1'b0, 1'b0, 1'b0);
            send_frame(8'(8'hF0 - i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i == 8), -1);
            idle(DIV);
        end
        check("pp_count", int'(fifo_count_o), 8);
        check("pp_overrun", int'(overrun_o), 0);
        for (int i = 0; i < 8; i++) pop_entry();
        check("pp_empty", int'(ready_o), 0);

        // Reset mid-DATA empties the FIFO and returns to IDLE.
        expect_entry(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(DIV);
        wait_ready();
        send_frame(8'h77, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        sb.delete();
        check("rstmid_count", int'(fifo_count_o), 0);
        check("rstmid_ready", int'(ready_o), 0);
        idle(4 * DIV);
        check("rstmid_quiet", int'(fifo_count_o), 0);
        expect_entry(8'h42, 1'b0, 1'b0, 1'b0);
        send_frame(8'h42, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(DIV);
        wait_ready();
        pop_entry();

        // One-cycle inverted glitch at each data bit's sample point.
`ifdef UART_RX_MAJORITY_EN
        expect_entry(8'hA5, 1'b0, 1'b0, 1'b0);
`else
        expect_entry(8'h5A, 1'b0, 1'b0, 1'b0);
`endif
        send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(DIV);
        wait_ready();
        pop_entry();
        check("final_empty", int'(fifo_count_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
